// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e   : controller state, 2-bit encoding (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width, never below 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // $clog2(1) is 0, but the counter needs at least one bit to exist.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder, reused as the arithmetic core of the serial adder.
// Ports:
//   carryIn  in  carry into this bit
//   in1      in  operand A bit
//   in2      in  operand B bit
//   out      out sum bit
//   carryOut out carry out of this bit
module FULLADDER (
  input  logic carryIn,
  input  logic in1,
  input  logic in2,
  output logic out,
  output logic carryOut
);

  assign out      = in1 ^ in2 ^ carryIn;
  assign carryOut = (in1 & in2) | (carryIn & (in1 ^ in2));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder plus a carry flip-flop, one bit
// per clock, LSB first, under a start/busy/done handshake.
// Handshake: start is accepted on a rising edge only while the controller is
// in IDLE or DONE; that edge samples in1/in2/carryIn. busy is high for the
// WIDTH cycles of RUN; done is high for exactly one cycle afterwards, in the
// same cycle that out/carryOut first show the new result. start while busy is
// ignored.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   operation request
//   in1, in2  in   WIDTH-bit operands
//   carryIn   in   initial carry
//   busy      out  high while adding
//   done      out  one-cycle completion pulse
//   out       out  sum of last completed addition
//   carryOut  out  final carry of last completed addition
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryOut
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  // a_q doubles as the sum shift register: each RUN edge consumes a_q[0] and
  // shifts the new sum bit in at the top, so after WIDTH edges it holds the sum.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] a_shift;

  FULLADDER u_fa (
    .carryIn  (c_q),
    .in1      (a_q[0]),
    .in2      (b_q[0]),
    .out      (fa_s),
    .carryOut (fa_co)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign a_shift = fa_s;
    end else begin : g_wn
      assign a_shift = {fa_s, a_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          c_d     = carryIn;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_shift;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        // Result registers move only here, so partial sums never reach out.
        if (cnt_q == LAST) begin
          out_d   = a_shift;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign carryOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=16 (id 0) and WIDTH=1 (id 1).
module tb_serial_adder;

  localparam int W0 = 16;
  localparam int W1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst0, start0, cin0, busy0, done0, cout0;
  logic [W0-1:0] in1_0, in2_0, out0;
  logic          rst1, start1, cin1, busy1, done1, cout1;
  logic [W1-1:0] in1_1, in2_1, out1;

  serial_adder #(.WIDTH(W0)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .in1(in1_0), .in2(in2_0),
    .carryIn(cin0), .busy(busy0), .done(done0), .out(out0), .carryOut(cout0)
  );

  serial_adder #(.WIDTH(W1)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .in1(in1_1), .in2(in2_1),
    .carryIn(cin1), .busy(busy1), .done(done1), .out(out1), .carryOut(cout1)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [64:0] val;
    int          cyc;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          next_ok[2];
  int          busy_lo[2];
  int          busy_hi[2];
  logic [64:0] held[2];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  function automatic int wid(input int id);
    return (id != 0) ? W1 : W0;
  endfunction

  function automatic int q_size(input int id);
    return (id != 0) ? exp_q1.size() : exp_q0.size();
  endfunction

  function automatic exp_t q_front(input int id);
    return (id != 0) ? exp_q1[0] : exp_q0[0];
  endfunction

  task automatic q_pop(input int id);
    if (id != 0) void'(exp_q1.pop_front());
    else         void'(exp_q0.pop_front());
  endtask

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // After a reset edge: nothing in flight, outputs zero, next edge may accept.
  task automatic model_reset(input int id);
    if (id != 0) exp_q1.delete();
    else         exp_q0.delete();
    held[id]    = '0;
    busy_lo[id] = 1;
    busy_hi[id] = 0;
    next_ok[id] = cyc + 1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int id, input logic dn, input logic bs, input logic [64:0] res);
    bit   exp_dn;
    exp_t e;
    exp_dn = (q_size(id) > 0) && (q_front(id).cyc == cyc);
    chk((id != 0) ? "busy_w1" : "busy_w16", bs, (cyc >= busy_lo[id] && cyc <= busy_hi[id]));
    chk((id != 0) ? "done_w1" : "done_w16", dn, exp_dn);
    if (exp_dn) begin
      e = q_front(id);
      q_pop(id);
      held[id] = e.val;
      chk((id != 0) ? "result_w1" : "result_w16", res, held[id]);
    end else begin
      chk((id != 0) ? "hold_w1" : "hold_w16", res, held[id]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, done0, busy0, {48'b0, cout0, out0});
      mon(1, done1, busy1, {63'b0, cout1, out1});
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready(input int id);
    while (cyc + 1 < next_ok[id]) tick();
  endtask

  task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b, input logic c);
    int          j;
    int          w;
    logic [63:0] m;
    logic [64:0] v;
    w = wid(id);
    m = (64'd1 << w) - 64'd1;
    v = 65'(a & m) + 65'(b & m) + 65'(c);
    if (id != 0) begin
      start1 = 1'b1; in1_1 = a[0]; in2_1 = b[0]; cin1 = c;
    end else begin
      start0 = 1'b1; in1_0 = a[15:0]; in2_0 = b[15:0]; cin0 = c;
    end
    j = cyc + 1;
    if (j >= next_ok[id]) begin
      if (id != 0) exp_q1.push_back('{v, j + w});
      else         exp_q0.push_back('{v, j + w});
      busy_lo[id] = j;
      busy_hi[id] = j + w - 1;
      next_ok[id] = j + w + 1;
    end
    tick();
    // Operands wander after the sampling edge; the sum must not care.
    if (id != 0) begin
      start1 = 1'b0; in1_1 = 1'($urandom); in2_1 = 1'($urandom); cin1 = 1'($urandom);
    end else begin
      start0 = 1'b0; in1_0 = 16'($urandom); in2_0 = 16'($urandom); cin0 = 1'($urandom);
    end
  endtask

  task automatic rst_pulse(input int id, input logic with_start);
    if (id != 0) begin
      rst1 = 1'b1; start1 = with_start;
    end else begin
      rst0 = 1'b1; start0 = with_start; in1_0 = 16'hBEEF; in2_0 = 16'h1111;
    end
    tick();
    model_reset(id);
    if (id != 0) begin
      rst1 = 1'b0; start1 = 1'b0;
      chk("reset_state_w1", {busy1, done1, cout1, out1}, '0);
    end else begin
      rst0 = 1'b0; start0 = 1'b0;
      chk("reset_state_w16", {busy0, done0, cout0, out0}, '0);
    end
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic random_ops(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        wait_ready(id);
        idle($urandom_range(0, 1));
      end else begin
        idle($urandom_range(0, 5));
      end
      issue(id, rand_op(), rand_op(), 1'($urandom));
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst0 = 1'b1; start0 = 1'b0; in1_0 = '0; in2_0 = '0; cin0 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; in1_1 = '0; in2_1 = '0; cin1 = 1'b0;
    @(posedge clk);
    tick();
    model_reset(0);
    model_reset(1);
    rst0 = 1'b0;
    rst1 = 1'b0;
    chk("init_w16", {busy0, done0, cout0, out0}, '0);
    chk("init_w1", {busy1, done1, cout1, out1}, '0);
    mon_en = 1'b1;

    // Directed WIDTH=16 cases
    wait_ready(0); issue(0, 64'h0001, 64'h0001, 1'b0);
    wait_ready(0); issue(0, 64'hFFFF, 64'h0000, 1'b1);
    wait_ready(0); issue(0, 64'h1234, 64'h4321, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      issue(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      idle(2);
    end

    // Abort mid-run; no done may follow
    wait_ready(0); issue(0, 64'hAAAA, 64'h5555, 1'b1);
    idle(7);
    rst_pulse(0, 1'b0);
    idle(20);
    // Reset together with start: start dropped
    rst_pulse(0, 1'b1);
    idle(20);

    // Back-to-back: second start issued in the DONE cycle
    wait_ready(0); issue(0, 64'h0F0F, 64'h00F1, 1'b0);
    wait_ready(0); issue(0, 64'hFFFF, 64'hFFFF, 1'b1);

    random_ops(0, 1000);

    // WIDTH=1
    wait_ready(1); issue(1, 64'h1, 64'h1, 1'b1);
    wait_ready(1); issue(1, 64'h1, 64'h0, 1'b0);
    random_ops(1, 200);
    wait_ready(1); issue(1, 64'h1, 64'h1, 1'b0);
    rst_pulse(1, 1'b0);
    idle(5);
    random_ops(1, 50);

    // Drain with a bounded wait
    for (int i = 0; i < 100 && (q_size(0) + q_size(1)) > 0; i++) tick();
    chk("drain", 65'(q_size(0) + q_size(1)), '0);
    idle(2);
    summary();
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    n_bad++;
    summary();
    $finish;
  end

endmodule
